// File: rtl/syncfifo_wm_if.sv
// Write/read handshake and status bundle shared by syncfifo_wm and its neighbours.
// The master side pushes and pops; the slave side is the FIFO itself.
interface syncfifo_wm_if #(
  parameter int WID = 32
);
  logic           vldin;
  logic [WID-1:0] din;
  logic           readout;
  logic [WID-1:0] dout;
  logic           full;
  logic           almost_full;
  logic           empty;
  logic           almost_empty;
  logic [15:0]    count;
  logic [15:0]    max_count;
  logic           overflow;
  logic           underflow;

  modport master (
    output vldin, din, readout,
    input  dout, full, almost_full, empty, almost_empty,
           count, max_count, overflow, underflow
  );

  modport slave (
    input  vldin, din, readout,
    output dout, full, almost_full, empty, almost_empty,
           count, max_count, overflow, underflow
  );
endinterface

// File: rtl/syncfifo_wm_outreg.sv
// Output register stage for syncfifo_wm: holds the head entry in a flop so dout
// has no array read in its path. valid marks whether the held word is live.
module syncfifo_wm_outreg #(
  parameter int WID = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           softreset,
  input  logic           load,
  input  logic           pop,
  input  logic [WID-1:0] d,
  output logic [WID-1:0] q,
  output logic           valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (softreset) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  // Data is qualified by valid, so it never needs a reset value.
  always_ff @(posedge clk) begin
    if (load) q <= d;
  end
endmodule

// File: rtl/syncfifo_wm.sv
// Single-clock FIFO with almost-full/almost-empty watermarks, sticky error flags,
// a high-water-mark monitor and an optional registered (fall-through) output.
module syncfifo_wm #(
  parameter int WID      = 32,
  parameter int DEPTH    = 8,
  parameter int AWID     = $clog2(DEPTH),
  parameter int REGOUT   = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         softreset,
  input  logic         clr_err,
  syncfifo_wm_if.slave f
);
  localparam int              CWID     = $clog2(DEPTH + 1);
  localparam logic [CWID-1:0] DEPTH_C  = CWID'(DEPTH);
  localparam logic [CWID-1:0] AF_C     = CWID'(AF_LEVEL);
  localparam logic [CWID-1:0] AE_C     = CWID'(AE_LEVEL);
  localparam logic [AWID-1:0] LAST_PTR = AWID'(DEPTH - 1);

  logic [WID-1:0]  mem [DEPTH];
  logic [AWID-1:0] wptr;
  logic [AWID-1:0] rptr;
  logic [CWID-1:0] cnt;
  logic [CWID-1:0] cnt_next;
  logic [CWID-1:0] max_q;
  logic            ovf_q;
  logic            udf_q;
  logic            full_int;
  logic            empty_int;
  logic            wr_acc;
  logic            rd_acc;
  logic            arr_pop;
  logic [WID-1:0]  dout_int;

  // DEPTH need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [AWID-1:0] ptr_inc(input logic [AWID-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AWID'(1);
  endfunction

  assign full_int = (cnt == DEPTH_C);
  assign wr_acc   = f.vldin && !full_int;
  assign rd_acc   = f.readout && !empty_int;

  // NOTE: every signal driven in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_next = cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_next = cnt + CWID'(1);
      2'b01:   cnt_next = cnt - CWID'(1);
      default: cnt_next = cnt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (softreset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_acc)  wptr <= ptr_inc(wptr);
      if (arr_pop) rptr <= ptr_inc(rptr);
      cnt <= cnt_next;
      // A new error in the same cycle as clr_err keeps the flag set.
      ovf_q <= (f.vldin && full_int)    || (ovf_q && !clr_err);
      udf_q <= (f.readout && empty_int) || (udf_q && !clr_err);
      if (clr_err) begin
        max_q <= cnt;
      end else if (cnt_next > max_q) begin
        max_q <= cnt_next;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed after
  // a write, so a reset would only cost routing and reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= f.din;
  end

  generate
    if (REGOUT != 0) begin : g_regout
      logic ovalid;
      logic arr_nonempty;
      logic load;

      // Array occupancy is cnt minus the entry parked in the output register.
      assign arr_nonempty = (cnt != CWID'(ovalid));
      assign load         = (!ovalid || rd_acc) && arr_nonempty;
      assign arr_pop      = load;
      assign empty_int    = !ovalid;

      syncfifo_wm_outreg #(
        .WID (WID)
      ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .softreset (softreset),
        .load      (load),
        .pop       (rd_acc),
        .d         (mem[rptr]),
        .q         (dout_int),
        .valid     (ovalid)
      );
    end else begin : g_comb
      assign arr_pop   = rd_acc;
      assign empty_int = (cnt == '0);
      assign dout_int  = mem[rptr];
    end
  endgenerate

  assign f.dout         = dout_int;
  assign f.full         = full_int;
  assign f.empty        = empty_int;
  assign f.almost_full  = (cnt >= AF_C);
  assign f.almost_empty = (cnt <= AE_C);
  assign f.count        = 16'(cnt);
  assign f.max_count    = 16'(max_q);
  assign f.overflow     = ovf_q;
  assign f.underflow    = udf_q;
endmodule

// File: tb/tb_syncfifo_wm.sv
// Directed bench for syncfifo_wm: DEPTH=8 combinational output, DEPTH=5 wrap,
// and DEPTH=4 registered output, each on its own instance.
module tb_syncfifo_wm;
  logic clk = 1'b0;
  logic rst_n;
  logic sr8, ce8, sr5, ce5, sr4, ce4;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  syncfifo_wm_if #(.WID(32)) b8 ();
  syncfifo_wm_if #(.WID(32)) b5 ();
  syncfifo_wm_if #(.WID(32)) b4 ();

  syncfifo_wm #(.WID(32), .DEPTH(8), .REGOUT(0)) u8 (
    .clk(clk), .rst_n(rst_n), .softreset(sr8), .clr_err(ce8), .f(b8)
  );
  syncfifo_wm #(.WID(32), .DEPTH(5), .REGOUT(0)) u5 (
    .clk(clk), .rst_n(rst_n), .softreset(sr5), .clr_err(ce5), .f(b5)
  );
  syncfifo_wm #(.WID(32), .DEPTH(4), .REGOUT(1)) u4 (
    .clk(clk), .rst_n(rst_n), .softreset(sr4), .clr_err(ce4), .f(b4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock and land 1 ns after the edge for driving and sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] q5[$];
  logic [31:0] nxt5;
  int          peak5;
  string       ops5;
  byte         op;

  initial begin
    rst_n = 1'b0;
    {sr8, ce8, sr5, ce5, sr4, ce4} = '0;
    b8.vldin = 0; b8.readout = 0; b8.din = '0;
    b5.vldin = 0; b5.readout = 0; b5.din = '0;
    b4.vldin = 0; b4.readout = 0; b4.din = '0;
    #12 rst_n = 1'b1;

    // Reset state
    check("rst_empty", b8.empty, 1);
    check("rst_full", b8.full, 0);
    check("rst_ae", b8.almost_empty, 1);
    check("rst_af", b8.almost_full, 0);
    check("rst_cnt", b8.count, 0);
    check("rst_max", b8.max_count, 0);
    check("rst_r_empty", b4.empty, 1);

    // Fill DEPTH=8 with 1..8
    b8.vldin = 1;
    for (int i = 1; i <= 8; i++) begin
      b8.din = i;
      tick();
      check("fill_cnt", b8.count, i);
      check("fill_af", b8.almost_full, (i >= 6));
      check("fill_full", b8.full, (i == 8));
    end
    b8.din = 32'h99;
    tick();
    b8.vldin = 0;
    check("ovf_set", b8.overflow, 1);
    check("ovf_cnt", b8.count, 8);
    check("max_full", b8.max_count, 8);

    // Drain 1..8, then one extra read
    b8.readout = 1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_dout", b8.dout, i);
      tick();
      check("drain_cnt", b8.count, 8 - i);
    end
    check("drain_empty", b8.empty, 1);
    check("drain_ae", b8.almost_empty, 1);
    tick();
    b8.readout = 0;
    check("udf_set", b8.underflow, 1);
    check("udf_ovf_held", b8.overflow, 1);
    check("udf_cnt", b8.count, 0);
    ce8 = 1;
    tick();
    ce8 = 0;
    check("clr_ovf", b8.overflow, 0);
    check("clr_udf", b8.underflow, 0);
    check("clr_max", b8.max_count, 0);

    // Simultaneous push/pop while full
    b8.vldin = 1;
    for (int i = 0; i < 8; i++) begin
      b8.din = 32'h10 + i;
      tick();
    end
    check("sf_full", b8.full, 1);
    b8.readout = 1;
    b8.din = 32'hEE;
    check("sf_pop_oldest", b8.dout, 32'h10);
    tick();
    b8.vldin = 0;
    b8.readout = 0;
    check("sf_cnt", b8.count, 7);
    check("sf_ovf", b8.overflow, 1);
    check("sf_notfull", b8.full, 0);
    b8.readout = 1;
    for (int i = 1; i < 8; i++) begin
      check("sf_drain", b8.dout, 32'h10 + i);
      tick();
    end
    b8.readout = 0;
    check("sf_empty", b8.empty, 1);

    // Simultaneous push/pop while empty
    b8.vldin = 1;
    b8.readout = 1;
    b8.din = 32'h55;
    tick();
    b8.vldin = 0;
    b8.readout = 0;
    check("se_cnt", b8.count, 1);
    check("se_udf", b8.underflow, 1);
    check("se_dout", b8.dout, 32'h55);

    // Softreset with 5 entries held
    b8.vldin = 1;
    for (int i = 1; i <= 4; i++) begin
      b8.din = 32'hA0 + i;
      tick();
    end
    b8.vldin = 0;
    check("sr_pre_cnt", b8.count, 5);
    sr8 = 1;
    tick();
    sr8 = 0;
    check("sr_cnt", b8.count, 0);
    check("sr_empty", b8.empty, 1);
    check("sr_ovf", b8.overflow, 0);
    check("sr_udf", b8.underflow, 0);
    check("sr_max", b8.max_count, 0);
    b8.vldin = 1;
    b8.din = 32'hB1;
    tick();
    b8.vldin = 0;
    check("sr_post_cnt", b8.count, 1);
    check("sr_post_dout", b8.dout, 32'hB1);
    b8.readout = 1;
    tick();
    b8.readout = 0;
    check("sr_post_empty", b8.empty, 1);

    // DEPTH=5 interleaved traffic; model queue tracks order and occupancy
    ops5  = "WWWWRBBRWRBBRWBRBRWR";
    nxt5  = 32'h50;
    peak5 = 0;
    for (int k = 0; k < ops5.len(); k++) begin
      op = ops5[k];
      b5.vldin   = (op == "W" || op == "B");
      b5.readout = (op == "R" || op == "B");
      b5.din     = nxt5;
      if (b5.readout) check("d5_dout", b5.dout, q5[0]);
      tick();
      if (b5.readout) void'(q5.pop_front());
      if (b5.vldin) begin
        q5.push_back(nxt5);
        nxt5++;
      end
      if (q5.size() > peak5) peak5 = q5.size();
      check("d5_cnt", b5.count, q5.size());
    end
    b5.vldin = 0;
    b5.readout = 0;
    check("d5_max", b5.max_count, peak5);
    check("d5_peak4", b5.max_count, 4);
    check("d5_empty", b5.empty, 1);
    check("d5_udf", b5.underflow, 0);
    check("d5_ovf", b5.overflow, 0);

    // REGOUT=1, DEPTH=4: two-cycle write-to-read latency
    b4.vldin = 1;
    b4.din = 32'h71;
    tick();
    b4.vldin = 0;
    check("r_empty_t1", b4.empty, 1);
    check("r_cnt_t1", b4.count, 1);
    tick();
    check("r_empty_t2", b4.empty, 0);
    check("r_dout_t2", b4.dout, 32'h71);
    b4.vldin = 1;
    b4.din = 32'h72;
    tick();
    check("r_cnt2", b4.count, 2);

    // Streaming: one word per cycle at a stable count
    b4.readout = 1;
    for (int k = 0; k < 8; k++) begin
      b4.din = 32'h73 + k;
      check("r_stream_dout", b4.dout, 32'h71 + k);
      check("r_stream_vld", b4.empty, 0);
      tick();
      check("r_stream_cnt", b4.count, 2);
    end
    b4.readout = 0;
    b4.din = 32'h7B;
    tick();
    b4.din = 32'h7C;
    tick();
    b4.vldin = 0;
    check("r_cnt4", b4.count, 4);
    check("r_full", b4.full, 1);
    check("r_af", b4.almost_full, 1);
    b4.readout = 1;
    for (int k = 0; k < 4; k++) begin
      check("r_drain", b4.dout, 32'h79 + k);
      tick();
    end
    b4.readout = 0;
    check("r_end_empty", b4.empty, 1);
    check("r_end_cnt", b4.count, 0);
    check("r_end_udf", b4.underflow, 0);

    // Asynchronous reset in the middle of a write burst
    b8.readout = 1;
    tick();
    b8.readout = 0;
    check("ar_udf_pre", b8.underflow, 1);
    b8.vldin = 1;
    b8.din = 32'hC0;
    tick();
    b8.din = 32'hC1;
    tick();
    check("ar_pre_cnt", b8.count, 2);
    #3 rst_n = 1'b0;
    #1;
    check("ar_cnt", b8.count, 0);
    check("ar_empty", b8.empty, 1);
    check("ar_udf", b8.underflow, 0);
    check("ar_max", b8.max_count, 0);
    b8.vldin = 0;
    @(negedge clk);
    rst_n = 1'b1;
    b8.vldin = 1;
    b8.din = 32'hD1;
    tick();
    b8.vldin = 0;
    check("ar_post_cnt", b8.count, 1);
    check("ar_post_dout", b8.dout, 32'hD1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
